// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode constants, format encodings, field positions and stage occupancy states
package mips_isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_t;
  function automatic logic [1:0] fmt_of(input logic [5:0] op);
    return (op == OP_RTYPE) ? FMT_R : (op == OP_J || op == OP_JAL) ? FMT_J : FMT_I;
  endfunction
endpackage

// File: rtl/ins_field_decode.sv
// ins_field_decode: combinational split of a MIPS word into format-gated fields and targets
module ins_field_decode
  import mips_isa_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  output logic [1:0]        fmt,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] jtarget,
  output logic [DATA_W-1:0] btarget
);
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] pc4;
  logic              is_r;
  logic              is_i;
  logic              is_j;
  always_comb begin
    opcode  = instr[OPC_LSB +: 6];
    fmt     = fmt_of(opcode);
    is_r    = fmt == FMT_R;
    is_i    = fmt == FMT_I;
    is_j    = fmt == FMT_J;
    imm     = instr[15:0];
    sext    = {{(DATA_W-16){imm[15]}}, imm};
    pc4     = pc + DATA_W'(4);
    rs      = is_j ? '0 : instr[RS_LSB +: 5];
    rt      = is_j ? '0 : instr[RT_LSB +: 5];
    rd      = is_r ? instr[RD_LSB +: 5] : '0;
    shamt   = is_r ? instr[SHAMT_LSB +: 5] : '0;
    funct   = is_r ? instr[5:0] : '0;
    // logical immediates zero-extend; everything else in I-format sign-extends
    imm_ext = !is_i ? '0 :
              (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) ? {{(DATA_W-16){1'b0}}, imm} : sext;
    jtarget = is_j ? {pc4[DATA_W-1:28], instr[25:0], 2'b00} : '0;
    btarget = is_i ? pc4 + (sext << 2) : '0;
  end
endmodule

// File: rtl/ins_decode_stage.sv
// ins_decode_stage: registered MIPS decode stage with valid/ready handshake and 2-entry skid buffer
module ins_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_fmt,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [DATA_W-1:0] out_imm_ext,
  output logic [DATA_W-1:0] out_jtarget,
  output logic [DATA_W-1:0] out_btarget,
  output logic [DATA_W-1:0] out_pc
);
  typedef struct packed {
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] jtarget;
    logic [DATA_W-1:0] btarget;
    logic [DATA_W-1:0] pc;
  } dec_t;
  dec_t dec;
  dec_t out_q;
  dec_t skid_q;
  occ_t state;
  logic accept;
  ins_field_decode #(.DATA_W(DATA_W)) u_fd (
    .instr   (in_instr),
    .pc      (in_pc),
    .fmt     (dec.fmt),
    .opcode  (dec.opcode),
    .rs      (dec.rs),
    .rt      (dec.rt),
    .rd      (dec.rd),
    .shamt   (dec.shamt),
    .funct   (dec.funct),
    .imm_ext (dec.imm_ext),
    .jtarget (dec.jtarget),
    .btarget (dec.btarget)
  );
  assign dec.pc    = in_pc;
  assign out_valid = state != ST_EMPTY;
  // without the skid register FULL is unreachable and ready must look at out_ready
  assign in_ready  = (SKID_EN != 0) ? (state != ST_FULL) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          out_q <= dec;
          state <= ST_ONE;
        end
        ST_ONE: if (accept && !out_ready) begin
          skid_q <= dec;
          state  <= ST_FULL;
        end else if (accept) begin
          out_q <= dec;
        end else if (out_ready) begin
          state <= ST_EMPTY;
        end
        ST_FULL: if (out_ready) begin
          out_q <= skid_q;
          state <= ST_ONE;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end
  assign out_fmt     = out_q.fmt;
  assign out_opcode  = out_q.opcode;
  assign out_rs      = out_q.rs;
  assign out_rt      = out_q.rt;
  assign out_rd      = out_q.rd;
  assign out_shamt   = out_q.shamt;
  assign out_funct   = out_q.funct;
  assign out_imm_ext = out_q.imm_ext;
  assign out_jtarget = out_q.jtarget;
  assign out_btarget = out_q.btarget;
  assign out_pc      = out_q.pc;
endmodule
